keyboard_ctrl: RTL
==================

KEYBOARD_CTRL -- requirements
Module: keyboard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: max clk cycles allowed between first and second character of a code.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  received ASCII character from the serial receiver.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid; one-cycle strobe per character.
REQ-006 SHALL have ports key_left, key_right, key_jump, key_start  output  1 each  held state of A, D, SPACE, ENTER.
REQ-007 SHALL have ports jump_pulse, start_pulse  output  1 each  one-cycle strobe on press edge of SPACE, ENTER.
REQ-008 SHALL have port code_err  output  1  one-cycle strobe on pair timeout.

Function
REQ-009 Each scan code SHALL arrive as two ASCII characters, high character first; code = {first, second} (16 bits).
REQ-010 Code constants SHALL be: A = 0x3143, D = 0x3233, SPACE = 0x3239, ENTER = 0x3541, RELEASED = 0x4630.
REQ-011 FSM SHALL have states WAIT_HI, WAIT_LO, DECODE.
REQ-012 WAIT_HI: on rx_valid, latch rx_data as high byte, clear timeout counter, go WAIT_LO; else stay.
REQ-013 WAIT_LO: on rx_valid, latch rx_data as low byte, go DECODE; else increment timeout counter.
REQ-014 WAIT_LO: when counter reaches TIMEOUT_CYCLES-1 with no rx_valid, discard high byte, pulse code_err for one cycle, go WAIT_HI; break_pending unchanged.
REQ-015 DECODE SHALL last exactly one cycle, then go WAIT_HI; rx_valid in DECODE SHALL be ignored.
REQ-016 Decode, code == RELEASED: set break_pending; no key change.
REQ-017 Decode, code in {A, D, SPACE, ENTER} with break_pending = 0: set matching key output (make).
REQ-018 Decode, code in {A, D, SPACE, ENTER} with break_pending = 1: clear matching key output (break), clear break_pending.
REQ-019 Decode, any other code: no key change; clear break_pending if set.
REQ-020 Key outputs SHALL be registered and update on the clock edge ending DECODE (2 cycles after second rx_valid).
REQ-021 jump_pulse/start_pulse SHALL assert for exactly one cycle, same cycle key_jump/key_start rises 0->1; repeated make of a held key (typematic) SHALL NOT re-pulse.
REQ-022 Keys SHALL be independent: left and right may both be held; no priority or masking.
REQ-023 Break of a key not held SHALL leave outputs unchanged, no pulse.
REQ-024 Timeout counter SHALL be wide enough for TIMEOUT_CYCLES without wrap; it SHALL hold at its limit, never wrapping.

Reset
REQ-025 rst_n low SHALL immediately force FSM to WAIT_HI, clear high/low byte registers, counter, break_pending.
REQ-026 rst_n low SHALL immediately drive all key outputs, pulses and code_err to 0.
REQ-027 Reset mid-pair SHALL discard the partial code; first rx_valid after release SHALL be treated as high byte.

Verification
REQ-028 Press: rx 0x31, 0x43 -> key_left = 1 two cycles after second strobe, stays 1; no pulse outputs.
REQ-029 Press/release SPACE: rx 0x32,0x39 -> key_jump = 1 with jump_pulse one cycle; then 0x46,0x30,0x32,0x39 -> key_jump = 0, no pulse.
REQ-030 Typematic: ENTER make sent three times -> key_start = 1, start_pulse exactly once.
REQ-031 Timeout (TIMEOUT_CYCLES = 16): rx 0x31, idle 16 cycles -> code_err one cycle; then 0x32,0x33 -> key_right = 1.
REQ-032 Unknown after break: 0x46,0x30,0x37,0x37 then 0x31,0x43 -> key_left = 1 (break_pending cleared by unknown code).
REQ-033 Async reset with key_left = 1 and FSM in WAIT_LO -> outputs 0 without clock edge; next pair 0x32,0x33 -> key_right = 1.

Source files
------------

// File: rtl/keyboard_ctrl.sv
// keyboard_ctrl: decodes two-character ASCII scan codes from a serial
// receiver into held key states (A, D, SPACE, ENTER) plus press strobes.
// A RELEASED prefix code turns the following key code into a break.
module keyboard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_left,
  output logic       key_right,
  output logic       key_jump,
  output logic       key_start,
  output logic       jump_pulse,
  output logic       start_pulse,
  output logic       code_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  localparam logic [15:0] CODE_A        = 16'h3143;
  localparam logic [15:0] CODE_D        = 16'h3233;
  localparam logic [15:0] CODE_SPACE    = 16'h3239;
  localparam logic [15:0] CODE_ENTER    = 16'h3541;
  localparam logic [15:0] CODE_RELEASED = 16'h4630;

  // key bit positions inside keys_q
  localparam int unsigned K_LEFT  = 0;
  localparam int unsigned K_RIGHT = 1;
  localparam int unsigned K_JUMP  = 2;
  localparam int unsigned K_START = 3;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    DECODE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            brk_q, brk_d;
  logic [3:0]      keys_q, keys_d;
  logic            jump_pulse_q, jump_pulse_d;
  logic            start_pulse_q, start_pulse_d;
  logic            code_err_q, code_err_d;

  logic [15:0]     code;
  logic [3:0]      key_hit;

  // Next-state, byte capture, timeout counting and key decode
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    brk_d      = brk_q;
    keys_d     = keys_q;
    code_err_d = 1'b0;
    code       = {hi_q, lo_q};
    key_hit    = '0;

    unique case (code)
      CODE_A:     key_hit[K_LEFT]  = 1'b1;
      CODE_D:     key_hit[K_RIGHT] = 1'b1;
      CODE_SPACE: key_hit[K_JUMP]  = 1'b1;
      CODE_ENTER: key_hit[K_START] = 1'b1;
      default:    key_hit          = '0;
    endcase

    unique case (state_q)
      WAIT_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          state_d = DECODE;
        end else if (cnt_q == CNT_LAST) begin
          // pair abandoned; break_pending deliberately left as-is
          hi_d       = '0;
          code_err_d = 1'b1;
          state_d    = WAIT_HI;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        state_d = WAIT_HI;
        if (code == CODE_RELEASED) begin
          brk_d = 1'b1;
        end else if (|key_hit) begin
          if (brk_q) begin
            keys_d = keys_q & ~key_hit;
            brk_d  = 1'b0;
          end else begin
            keys_d = keys_q | key_hit;
          end
        end else begin
          brk_d = 1'b0;
        end
      end
      default: state_d = WAIT_HI;
    endcase

    // strobe only on a real 0->1 edge, so typematic repeats do not re-pulse
    jump_pulse_d  = keys_d[K_JUMP]  & ~keys_q[K_JUMP];
    start_pulse_d = keys_d[K_START] & ~keys_q[K_START];
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_HI;
      hi_q          <= '0;
      lo_q          <= '0;
      cnt_q         <= '0;
      brk_q         <= 1'b0;
      keys_q        <= '0;
      jump_pulse_q  <= 1'b0;
      start_pulse_q <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      cnt_q         <= cnt_d;
      brk_q         <= brk_d;
      keys_q        <= keys_d;
      jump_pulse_q  <= jump_pulse_d;
      start_pulse_q <= start_pulse_d;
      code_err_q    <= code_err_d;
    end
  end

  assign key_left    = keys_q[K_LEFT];
  assign key_right   = keys_q[K_RIGHT];
  assign key_jump    = keys_q[K_JUMP];
  assign key_start   = keys_q[K_START];
  assign jump_pulse  = jump_pulse_q;
  assign start_pulse = start_pulse_q;
  assign code_err    = code_err_q;

endmodule
